// File: rtl/nat_join_4_pkg.sv
// Shared types and constants for the
// four-way token join.
package nat_ctrl_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned FREE_DELAY_DEF = 2;

  typedef enum logic [1:0] {
    COLLECT,
    FIRE,
    DELAY,
    RELEASE
  } state_t;

endpackage

// File: rtl/nat_join_4_if.sv
// Branch/downstream handshake bundle
// for the four-way token join.
interface nat_join_4_if;
  logic [3:0] i_drive;
  logic       i_freeNext;
  logic       o_driveNext;
  logic [3:0] o_free;
  logic       o_err;

  modport master (
    output i_drive,
    output i_freeNext,
    input  o_driveNext,
    input  o_free,
    input  o_err
  );

  modport slave (
    input  i_drive,
    input  i_freeNext,
    output o_driveNext,
    output o_free,
    output o_err
  );
endinterface

// File: rtl/nat_join_4_arrival_latch.sv
// One arrival bit: sticky set, clear on
// release, overrun detect on repeat drive.
module nat_arrival_latch (
  input  logic clk,
  input  logic rst,
  input  logic drive,
  input  logic clr,
  output logic q,
  output logic ovr
);

  // a drive landing on the release cycle
  // belongs to the next token
  assign ovr = drive & q & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= drive;
    end else begin
      q <= q | drive;
    end
  end

endmodule

// File: rtl/nat_join_4.sv
// Four-way token join: collect arrivals,
// fire downstream on credit, release later.
module nat_join_4
  import nat_ctrl_pkg::*;
#(
  parameter int unsigned FREE_DELAY =
    FREE_DELAY_DEF
) (
  input logic clk,
  input logic rst,
  nat_join_4_if.slave bus
);

  state_t           state;
  logic [3:0]       arr;
  logic [3:0]       ovr;
  logic             credit;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             inFire;
  logic             inRel;
  logic             canFire;

  assign full    = &(arr | bus.i_drive);
  assign inFire  = (state == FIRE);
  assign inRel   = (state == RELEASE);
  // a credit returning this edge is usable now
  assign canFire = credit | bus.i_freeNext;

  for (genvar k = 0; k < 4; k++) begin : g_arr
    nat_arrival_latch u_latch (
      .clk   (clk),
      .rst   (rst),
      .drive (bus.i_drive[k]),
      .clr   (inRel),
      .q     (arr[k]),
      .ovr   (ovr[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= COLLECT;
      credit          <= 1'b1;
      cnt             <= '0;
      bus.o_driveNext <= 1'b0;
      bus.o_free      <= 4'h0;
      bus.o_err       <= 1'b0;
    end else begin
      bus.o_driveNext <= 1'b0;
      bus.o_free      <= 4'h0;
      bus.o_err       <= (|ovr)
        | (bus.i_freeNext & credit & ~inFire);

      if (inFire) begin
        credit <= bus.i_freeNext;
      end else if (bus.i_freeNext) begin
        credit <= 1'b1;
      end

      unique case (state)
        COLLECT: begin
          if (full && canFire) begin
            state           <= FIRE;
            bus.o_driveNext <= 1'b1;
          end
        end
        FIRE: begin
          if (FREE_DELAY == 0) begin
            state      <= RELEASE;
            bus.o_free <= 4'hF;
          end else begin
            state <= DELAY;
            cnt   <= CNT_W'(FREE_DELAY);
          end
        end
        DELAY: begin
          if (cnt == CNT_W'(1)) begin
            state      <= RELEASE;
            bus.o_free <= 4'hF;
            cnt        <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          state <= COLLECT;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nat_join_4.sv
// Random and directed bench for nat_join_4,
// two delay settings against a timeline model.
module tb_nat_join_4;
  import nat_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nat_join_4_if ifA ();
  nat_join_4_if ifB ();

  nat_join_4 #(.FREE_DELAY(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  nat_join_4 #(.FREE_DELAY(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  int nAsserts = 0;
  int nFail    = 0;

  int         dly [2] = '{2, 0};
  logic [3:0] mArr [2];
  bit         mCred [2];
  bit         mFired [2];
  int         mFe [2];
  bit         eDrv [2];
  bit         eFree [2];
  bit         eErr [2];
  int         t = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nAsserts++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h",
        tag, t, got, exp);
    end
  endtask

  task automatic drive(
    input logic [3:0] d,
    input logic       f
  );
    ifA.i_drive    = d;
    ifA.i_freeNext = f;
    ifB.i_drive    = d;
    ifB.i_freeNext = f;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mArr[k]   = 4'h0;
      mCred[k]  = 1'b1;
      mFired[k] = 1'b0;
      mFe[k]    = 0;
      eDrv[k]   = 1'b0;
      eFree[k]  = 1'b0;
      eErr[k]   = 1'b0;
    end
  endtask

  // token timeline: fire decided at edge fe,
  // FIRE at fe+1, RELEASE at fe+2+D
  task automatic modelEdge(
    input logic [3:0] d,
    input logic       f
  );
    for (int k = 0; k < 2; k++) begin
      int D;
      bit inFire, inRel, coll, fire, err;
      D      = dly[k];
      inFire = mFired[k] && (t == mFe[k] + 1);
      inRel  = mFired[k] && (t == mFe[k] + 2 + D);
      coll   = !mFired[k] || (t >= mFe[k] + 3 + D);
      err    = (!inRel && ((d & mArr[k]) != 0))
        || (f && mCred[k] && !inFire);
      fire   = coll && ((mArr[k] | d) == 4'hF)
        && (mCred[k] || f);
      mArr[k] = inRel ? d : (mArr[k] | d);
      if (inFire) mCred[k] = f;
      else if (f) mCred[k] = 1'b1;
      if (fire) begin
        mFe[k]    = t;
        mFired[k] = 1'b1;
      end
      eDrv[k]  = fire;
      eFree[k] = mFired[k] && (t == mFe[k] + 1 + D);
      eErr[k]  = err;
    end
    t++;
  endtask

  task automatic checkOut();
    check("A.driveNext", ifA.o_driveNext, eDrv[0]);
    check("A.free", ifA.o_free, eFree[0] ? 4'hF : 4'h0);
    check("A.err", ifA.o_err, eErr[0]);
    check("B.driveNext", ifB.o_driveNext, eDrv[1]);
    check("B.free", ifB.o_free, eFree[1] ? 4'hF : 4'h0);
    check("B.err", ifB.o_err, eErr[1]);
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".A"},
      {ifA.o_driveNext, ifA.o_free, ifA.o_err}, 0);
    check({tag, ".B"},
      {ifB.o_driveNext, ifB.o_free, ifB.o_err}, 0);
  endtask

  task automatic cycle(
    input logic [3:0] d,
    input logic       f
  );
    drive(d, f);
    @(posedge clk);
    modelEdge(d, f);
    @(negedge clk);
    checkOut();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(4'h0, 1'b0);
  endtask

  task automatic doReset();
    drive(4'h0, 1'b0);
    rst = 1'b0;
    #1;
    checkZero("rstAsync");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkZero("rstHeld");
    rst = 1'b1;
    #1;
    checkZero("rstRelease");
  endtask

  initial begin
    drive(4'h0, 1'b0);
    modelReset();
    #2 rst = 1'b0;
    #1 checkZero("rstInit");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // staggered arrivals, one per cycle
    cycle(4'h1, 1'b0);
    cycle(4'h2, 1'b0);
    cycle(4'h4, 1'b0);
    cycle(4'h8, 1'b0);
    idle(6);

    // credit back, then all four at once
    cycle(4'h0, 1'b1);
    cycle(4'hF, 1'b0);
    idle(6);

    // full set held while credit is zero
    cycle(4'hF, 1'b0);
    idle(5);
    cycle(4'h0, 1'b1);
    idle(6);

    // duplicate drive on branch 2
    cycle(4'h0, 1'b1);
    cycle(4'h4, 1'b0);
    cycle(4'h4, 1'b0);
    cycle(4'h1, 1'b0);
    cycle(4'h2, 1'b0);
    cycle(4'h8, 1'b0);
    idle(6);

    // arrival landing in the release cycle
    cycle(4'h0, 1'b1);
    cycle(4'hF, 1'b0);
    idle(3);
    cycle(4'h1, 1'b0);
    idle(2);
    cycle(4'h0, 1'b1);
    cycle(4'hE, 1'b0);
    idle(6);

    // reset while the long-delay copy is in DELAY
    cycle(4'h0, 1'b1);
    cycle(4'hF, 1'b0);
    cycle(4'h0, 1'b0);
    doReset();
    idle(6);
    cycle(4'hF, 1'b0);
    idle(6);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      logic       f;
      d = 4'($urandom) & 4'($urandom) & 4'($urandom);
      f = ($urandom_range(0, 5) == 0);
      cycle(d, f);
      if ($urandom_range(0, 499) == 0) doReset();
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
      nAsserts, nFail);
    $finish;
  end

endmodule
